// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the integer register file: pipeline writes win, long-latency results queue in a FIFO.
// Optional cycle trace of writes and squashes when WB_ARB_TRACE_EN is defined.
module regfile_wb_arbiter #(
   parameter int DEPTH = 4,
   parameter int DW    = 32,
   parameter int AW    = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pipe_we,
   input  logic [AW-1:0] pipe_waddr,
   input  logic [DW-1:0] pipe_wdata,
   input  logic          lu_valid,
   output logic          lu_ready,
   input  logic [AW-1:0] lu_waddr,
   input  logic [DW-1:0] lu_wdata,
   input  logic [AW-1:0] q_addr,
   output logic          q_busy,
   output logic          we,
   output logic [AW-1:0] waddr,
   output logic [DW-1:0] wdata
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = DEPTH[PW:0];

   logic [DEPTH-1:0]         live_q, live_d;
   logic [DEPTH-1:0][AW-1:0] addr_q;
   logic [DEPTH-1:0][DW-1:0] data_q;
   logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
   logic [PW:0]              count_q, count_d;
   logic                     we_q, we_d;
   logic [AW-1:0]            waddr_q, waddr_d;
   logic [DW-1:0]            wdata_q, wdata_d;

   logic pipe_wr, non_empty, head_live, push, pop;

   assign lu_ready = !rst && (count_q < FULL);
   assign we       = we_q;
   assign waddr    = waddr_q;
   assign wdata    = wdata_q;

   // A live head stalls only behind a pipeline write; a dead head always drains.
   always_comb begin
      pipe_wr   = pipe_we && (pipe_waddr != '0);
      non_empty = (count_q != '0);
      head_live = non_empty && live_q[head_q];
      push      = lu_valid && lu_ready;
      pop       = non_empty && !(pipe_wr && head_live);
   end

   always_comb begin
      live_d = live_q;
      for (int i = 0; i < DEPTH; i++)
         if (pipe_wr && (addr_q[i] == pipe_waddr)) live_d[i] = 1'b0;
      // Popped slots are cleared so stale entries never count as busy.
      if (pop) live_d[head_q] = 1'b0;
      if (push)
         live_d[tail_q] = (lu_waddr != '0) && !(pipe_wr && (pipe_waddr == lu_waddr));

      head_d  = pop  ? head_q + PW'(1) : head_q;
      tail_d  = push ? tail_q + PW'(1) : tail_q;
      count_d = count_q;
      if (push && !pop)      count_d = count_q + (PW+1)'(1);
      else if (pop && !push) count_d = count_q - (PW+1)'(1);

      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (pipe_wr) begin
         we_d    = 1'b1;
         waddr_d = pipe_waddr;
         wdata_d = pipe_wdata;
      end else if (head_live) begin
         we_d    = 1'b1;
         waddr_d = addr_q[head_q];
         wdata_d = data_q[head_q];
      end
   end

   always_comb begin
      q_busy = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         if (live_q[i] && (addr_q[i] == q_addr)) q_busy = 1'b1;
      if (q_addr == '0) q_busy = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         live_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         live_q  <= live_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_q] <= lu_waddr;
         data_q[tail_q] <= lu_wdata;
      end
   end

`ifdef WB_ARB_TRACE_EN
   always @(posedge clk) begin
      if (!rst) begin
         if (we_d) $display("time %3d r%d = %h", $time, waddr_d, wdata_d);
         for (int i = 0; i < DEPTH; i++)
            if (pipe_wr && live_q[i] && (addr_q[i] == pipe_waddr))
               $display("time %3d squash r%d", $time, addr_q[i]);
         if (push && pipe_wr && (lu_waddr == pipe_waddr))
            $display("time %3d squash r%d", $time, lu_waddr);
      end
   end
`else
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with fixed expectations plus a
// randomized run against a queue-based model of the write-back rules.
module tb_regfile_wb_arbiter;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pipe_we = 1'b0;
   logic [4:0]  pipe_waddr = '0;
   logic [31:0] pipe_wdata = '0;
   logic        lu_valid = 1'b0;
   logic        lu_ready;
   logic [4:0]  lu_waddr = '0;
   logic [31:0] lu_wdata = '0;
   logic [4:0]  q_addr = '0;
   logic        q_busy;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;

   int n_chk = 0;
   int n_fail = 0;

   regfile_wb_arbiter #(.DEPTH(DEPTH), .DW(32), .AW(5)) dut (
      .clk(clk), .rst(rst),
      .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
      .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
      .q_addr(q_addr), .q_busy(q_busy),
      .we(we), .waddr(waddr), .wdata(wdata)
   );

   always #5 clk = ~clk;

   // Reference model: queue of buffered results in arrival order.
   typedef struct { logic [4:0] a; logic [31:0] d; bit live; } ent_t;
   ent_t        fq[$];
   logic        e_we = 1'b0;
   logic [4:0]  e_wa = '0;
   logic [31:0] e_wd = '0;

   function automatic bit m_ready();
      return !rst && (fq.size() < DEPTH);
   endfunction

   function automatic bit m_busy(logic [4:0] a);
      if (a == 0) return 1'b0;
      foreach (fq[i]) if (fq[i].live && fq[i].a == a) return 1'b1;
      return 1'b0;
   endfunction

   task automatic m_step();
      ent_t h;
      bit   acc, pw;
      if (rst) begin
         fq.delete();
         e_we = 0; e_wa = 0; e_wd = 0;
      end else begin
         acc = lu_valid && (fq.size() < DEPTH);
         pw  = pipe_we && (pipe_waddr != 0);
         e_we = 0;
         if (pw) begin
            e_we = 1; e_wa = pipe_waddr; e_wd = pipe_wdata;
            if (fq.size() > 0 && !fq[0].live) void'(fq.pop_front());
         end else if (fq.size() > 0) begin
            h = fq.pop_front();
            if (h.live) begin e_we = 1; e_wa = h.a; e_wd = h.d; end
         end
         if (pw) foreach (fq[i]) if (fq[i].a == pipe_waddr) fq[i].live = 0;
         if (acc) begin
            h.a = lu_waddr; h.d = lu_wdata;
            h.live = (lu_waddr != 0) && !(pw && pipe_waddr == lu_waddr);
            fq.push_back(h);
         end
      end
   endtask

   // Advance one clock: model consumes this cycle's inputs, then we sit 1 time unit past the edge.
   task automatic cyc();
      m_step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      pipe_we = 0; pipe_waddr = 0; pipe_wdata = 0;
      lu_valid = 0; lu_waddr = 0; lu_wdata = 0; q_addr = 0;
   endtask

   task automatic idle(int n);
      clr();
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic test_reset();
      rst = 1; clr();
      cyc(); cyc();
      n_chk++;
      if ({we, waddr, wdata} !== 38'h0) begin
         n_fail++; $display("FAIL reset_out: got %b/%0d/%h want 0/0/0", we, waddr, wdata);
      end
      n_chk++;
      if (lu_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_ready: got %b want 0", lu_ready);
      end
      rst = 0; #1;
      n_chk++;
      if (lu_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready_release: got %b want 1", lu_ready);
      end
   endtask

   task automatic test_pipe_write();
      pipe_we = 1; pipe_waddr = 3; pipe_wdata = 32'h11;
      cyc();
      n_chk++;
      if ({we, waddr, wdata} !== {1'b1, 5'd3, 32'h11}) begin
         n_fail++; $display("FAIL pipe_write: got %b/%0d/%h want 1/3/00000011", we, waddr, wdata);
      end
      clr(); cyc();
      n_chk++;
      if (we !== 1'b0) begin
         n_fail++; $display("FAIL pipe_write_one_cycle: we got %b want 0", we);
      end
   endtask

   task automatic test_priority();
      lu_valid = 1; lu_waddr = 7; lu_wdata = 32'hAA;
      cyc();
      clr(); q_addr = 7;
      pipe_we = 1; pipe_waddr = 2; pipe_wdata = 32'h22; #1;
      n_chk++;
      if (q_busy !== 1'b1) begin n_fail++; $display("FAIL prio_busy_c2: got %b want 1", q_busy); end
      cyc();
      n_chk++;
      if ({we, waddr, wdata} !== {1'b1, 5'd2, 32'h22}) begin
         n_fail++; $display("FAIL prio_r2: got %b/%0d/%h want 1/2/00000022", we, waddr, wdata);
      end
      pipe_waddr = 4; pipe_wdata = 32'h44; #1;
      n_chk++;
      if (q_busy !== 1'b1) begin n_fail++; $display("FAIL prio_busy_c3: got %b want 1", q_busy); end
      cyc();
      n_chk++;
      if ({we, waddr, wdata} !== {1'b1, 5'd4, 32'h44}) begin
         n_fail++; $display("FAIL prio_r4: got %b/%0d/%h want 1/4/00000044", we, waddr, wdata);
      end
      pipe_we = 0; #1;
      n_chk++;
      if (q_busy !== 1'b1) begin n_fail++; $display("FAIL prio_busy_c4: got %b want 1", q_busy); end
      cyc();
      n_chk++;
      if ({we, waddr, wdata} !== {1'b1, 5'd7, 32'hAA}) begin
         n_fail++; $display("FAIL prio_r7: got %b/%0d/%h want 1/7/000000aa", we, waddr, wdata);
      end
      n_chk++;
      if (q_busy !== 1'b0) begin n_fail++; $display("FAIL prio_busy_c5: got %b want 0", q_busy); end
      idle(2);
   endtask

   task automatic test_full();
      pipe_we = 1; pipe_waddr = 20; pipe_wdata = 32'h20;
      for (int k = 1; k <= 4; k++) begin
         lu_valid = 1; lu_waddr = 5'(k); lu_wdata = 32'h100 + k; #1;
         n_chk++;
         if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_%0d: got %b want 1", k, lu_ready); end
         cyc();
      end
      lu_waddr = 5; lu_wdata = 32'h105;
      for (int k = 0; k < 2; k++) begin
         #1;
         n_chk++;
         if (lu_ready !== 1'b0) begin n_fail++; $display("FAIL full_holdoff_%0d: got %b want 0", k, lu_ready); end
         cyc();
      end
      clr();
      for (int k = 1; k <= 4; k++) begin
         cyc();
         n_chk++;
         if ({we, waddr, wdata} !== {1'b1, 5'(k), 32'h100 + k}) begin
            n_fail++; $display("FAIL full_drain_%0d: got %b/%0d/%h want 1/%0d/%h", k, we, waddr, wdata, k, 32'h100 + k);
         end
         if (k == 1) begin
            n_chk++;
            if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_return: got %b want 1", lu_ready); end
         end
      end
      cyc();
      n_chk++;
      if (we !== 1'b0) begin n_fail++; $display("FAIL full_no_fifth: we got %b want 0", we); end
      idle(1);
   endtask

   task automatic test_squash();
      int writes9;
      lu_valid = 1; lu_waddr = 9; lu_wdata = 32'h1;
      cyc();
      clr(); pipe_we = 1; pipe_waddr = 9; pipe_wdata = 32'h2;
      cyc();
      n_chk++;
      if ({we, waddr, wdata} !== {1'b1, 5'd9, 32'h2}) begin
         n_fail++; $display("FAIL squash_pipe: got %b/%0d/%h want 1/9/00000002", we, waddr, wdata);
      end
      clr(); q_addr = 9; #1;
      n_chk++;
      if (q_busy !== 1'b0) begin n_fail++; $display("FAIL squash_busy: got %b want 0", q_busy); end
      writes9 = 0;
      for (int k = 0; k < 3; k++) begin cyc(); if (we) writes9++; end
      n_chk++;
      if (writes9 != 0) begin n_fail++; $display("FAIL squash_dead_pop: %0d extra writes, want 0", writes9); end
      lu_valid = 1; lu_waddr = 9; lu_wdata = 32'h1;
      pipe_we = 1; pipe_waddr = 9; pipe_wdata = 32'h2;
      cyc();
      n_chk++;
      if ({we, waddr, wdata} !== {1'b1, 5'd9, 32'h2}) begin
         n_fail++; $display("FAIL squash_same: got %b/%0d/%h want 1/9/00000002", we, waddr, wdata);
      end
      clr(); q_addr = 9; #1;
      n_chk++;
      if (q_busy !== 1'b0) begin n_fail++; $display("FAIL squash_same_busy: got %b want 0", q_busy); end
      writes9 = 0;
      for (int k = 0; k < 3; k++) begin cyc(); if (we) writes9++; end
      n_chk++;
      if (writes9 != 0) begin n_fail++; $display("FAIL squash_same_dead: %0d extra writes, want 0", writes9); end
   endtask

   task automatic test_reg_zero();
      int wr;
      lu_valid = 1; lu_waddr = 0; lu_wdata = 32'h55; #1;
      n_chk++;
      if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL r0_ready: got %b want 1", lu_ready); end
      cyc();
      clr(); q_addr = 0;
      pipe_we = 1; pipe_waddr = 0; pipe_wdata = 32'h66; #1;
      n_chk++;
      if (q_busy !== 1'b0) begin n_fail++; $display("FAIL r0_busy: got %b want 0", q_busy); end
      wr = 0;
      for (int k = 0; k < 3; k++) begin cyc(); if (we) wr++; end
      n_chk++;
      if (wr != 0) begin n_fail++; $display("FAIL r0_no_write: %0d writes, want 0", wr); end
      idle(1);
   endtask

   task automatic test_reset_mid();
      int wr;
      pipe_we = 1; pipe_waddr = 20; pipe_wdata = 32'h20;
      for (int k = 0; k < 3; k++) begin
         lu_valid = 1; lu_waddr = 5'(10 + k); lu_wdata = 32'h300 + k;
         cyc();
      end
      clr(); rst = 1;
      cyc();
      n_chk++;
      if (we !== 1'b0) begin n_fail++; $display("FAIL rstmid_we: got %b want 0", we); end
      rst = 0; q_addr = 11; #1;
      n_chk++;
      if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", lu_ready); end
      n_chk++;
      if (q_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", q_busy); end
      wr = 0;
      for (int k = 0; k < 5; k++) begin cyc(); if (we) wr++; end
      n_chk++;
      if (wr != 0) begin n_fail++; $display("FAIL rstmid_no_write: %0d writes, want 0", wr); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         rst        = ($urandom_range(99) < 2);
         pipe_we    = ($urandom_range(99) < 40);
         pipe_waddr = 5'($urandom_range(7));
         pipe_wdata = $urandom;
         lu_valid   = ($urandom_range(99) < 60);
         lu_waddr   = 5'($urandom_range(7));
         lu_wdata   = $urandom;
         q_addr     = 5'($urandom_range(7));
         #1;
         n_chk++;
         if (lu_ready !== m_ready()) begin
            n_fail++; $display("FAIL rand_ready c%0d: got %b want %b", c, lu_ready, m_ready());
         end
         n_chk++;
         if (q_busy !== m_busy(q_addr)) begin
            n_fail++; $display("FAIL rand_busy c%0d r%0d: got %b want %b", c, q_addr, q_busy, m_busy(q_addr));
         end
         cyc();
         n_chk++;
         if ({we, waddr, wdata} !== {e_we, e_wa, e_wd}) begin
            n_fail++; $display("FAIL rand_out c%0d: got %b/%0d/%h want %b/%0d/%h", c, we, waddr, wdata, e_we, e_wa, e_wd);
         end
      end
      rst = 0; idle(DEPTH + 2);
   endtask

   initial begin
      test_reset();
      test_pipe_write();
      test_priority();
      test_full();
      test_squash();
      test_reg_zero();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
